// File: rtl/instr_pkg.sv
// Shared opcode constants, format/state enums and the field packer for
// instr_encoder. Optional immediate range checking: INSTR_ENC_CHECK_EN.
package instr_pkg;

    localparam int N_INSTR = 16;

    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] SUB_MOV_REG = 2'b00;
    localparam logic [1:0] SUB_MOV_IMM = 2'b10;
    localparam logic [1:0] SUB_LDR     = 2'b00;
    localparam logic [1:0] SUB_LDI     = 2'b11;
    localparam logic [1:0] SUB_STR     = 2'b00;

    typedef enum logic [2:0] {
        FMT_ALU,
        FMT_IMM8,
        FMT_MOVR,
        FMT_MEM,
        FMT_BR,
        FMT_HALT
    } fmt_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    function automatic fmt_e fmt_of(input logic [2:0] opc,
                                    input logic [1:0] op);
        fmt_e f;
        f = FMT_ALU;
        if (opc == OP_HALT)
            f = FMT_HALT;
        else if (opc == OP_B)
            f = FMT_BR;
        else if ((opc == OP_MOV && op == SUB_MOV_IMM) ||
                 (opc == OP_LDR && op == SUB_LDI))
            f = FMT_IMM8;
        else if (opc == OP_MOV && op == SUB_MOV_REG)
            f = FMT_MOVR;
        else if ((opc == OP_LDR && op == SUB_LDR) ||
                 (opc == OP_STR && op == SUB_STR))
            f = FMT_MEM;
        return f;
    endfunction

    function automatic logic [15:0] encode(
        input logic [2:0]  opc,
        input logic [1:0]  op,
        input fmt_e        fmt,
        input logic [2:0]  cond,
        input logic [2:0]  rd,
        input logic [2:0]  rn,
        input logic [2:0]  rm,
        input logic [1:0]  shift,
        input logic [15:0] imm5,
        input logic [15:0] imm8
    );
        logic [10:0] lo;
        lo = {rn, rd, shift, rm};
        case (fmt)
            FMT_IMM8: lo = {rd, imm8[7:0]};
            FMT_MOVR: lo = {3'b000, rd, shift, rm};
            FMT_MEM:  lo = {rn, rd, imm5[4:0]};
            FMT_BR:   lo = {cond, imm8[7:0]};
            FMT_HALT: lo = '0;
            default:  lo = {rn, rd, shift, rm};
        endcase
        return {opc, op, lo};
    endfunction

    // A value fits if every bit above the sign bit copies the sign bit.
    function automatic logic fits_s5(input logic [15:0] v);
        return (&v[15:4]) || !(|v[15:4]);
    endfunction

    function automatic logic fits_s8(input logic [15:0] v);
        return (&v[15:7]) || !(|v[15:7]);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; DEPTH must be a power of two.
// Push when full and pop when empty are ignored.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wptr_q <= wptr_q + AW'(1);
            if (do_pop)
                rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields into instruction words and streams them to memory.
// Define INSTR_ENC_CHECK_EN to reject out-of-range immediates via err.
module instr_encoder #(
    parameter int                N_INSTR    = instr_pkg::N_INSTR,
    parameter int                N_REGISTER = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    opCode,
    input  logic [1:0]                    op,
    input  logic [2:0]                    cond,
    input  logic [$clog2(N_REGISTER)-1:0] Rd,
    input  logic [$clog2(N_REGISTER)-1:0] Rn,
    input  logic [$clog2(N_REGISTER)-1:0] Rm,
    input  logic [1:0]                    shift,
    input  logic [15:0]                   sximm5,
    input  logic [15:0]                   sximm8,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [N_INSTR-1:0]            mem_wdata,
    input  logic                          mem_ready,
    output logic                          done,
    output logic                          err
);

    import instr_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    enc_state_e        state_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    fmt_e              fmt;
    logic [15:0]       word;
    logic              accept;
    logic              bad;
    logic              push;
    logic              pop;
    logic              is_halt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [N_INSTR-1:0] head;

    always_comb begin
        fmt = fmt_of(opCode, op);
    end

    assign word = encode(opCode, op, fmt, cond,
                         3'(Rd), 3'(Rn), 3'(Rm), shift,
                         sximm5, sximm8);

    assign is_halt  = (fmt == FMT_HALT);
    assign in_ready = !reset && (state_q == ST_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;

`ifdef INSTR_ENC_CHECK_EN
    logic err_q;

    assign bad = ((fmt == FMT_MEM) && !fits_s5(sximm5)) ||
                 ((fmt == FMT_IMM8 || fmt == FMT_BR) && !fits_s8(sximm8));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= accept && bad;
    end

    assign err = err_q;
`else
    logic unused_imm_hi;

    assign bad           = 1'b0;
    assign err           = 1'b0;
    assign unused_imm_hi = ^{sximm5[15:5], sximm8[15:8]};
`endif

    assign push = accept && !bad;
    assign pop  = !fifo_empty && mem_ready;

    instr_fifo #(
        .WIDTH (N_INSTR),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (N_INSTR'(word)),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_write = !fifo_empty;
    assign mem_wdata = fifo_empty ? '0 : head;
    assign mem_addr  = addr_q;
    assign done      = done_q;

    assign addr_d = pop ? addr_q + ADDR_W'(1) : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            addr_q <= BASE_ADDR;
        else
            addr_q <= addr_d;
    end

    // In DRAIN nothing is pushed, so the last entry out is the HALT word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (push && is_halt)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && fifo_count == CW'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure,
// reset mid-transfer, HALT/done and address wrap via a second instance.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  opCode;
    logic [1:0]  op;
    logic [2:0]  cond;
    logic [2:0]  Rd, Rn, Rm;
    logic [1:0]  shift;
    logic [15:0] sximm5, sximm8;
    logic        mem_ready;

    logic        in_ready, mem_write, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        in_ready_b, mem_write_b, done_b, err_b;
    logic [7:0]  mem_addr_b;
    logic [15:0] mem_wdata_b;

    int n_pass = 0;
    int n_total = 0;
    int nw = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(8'h00)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opCode(opCode), .op(op), .cond(cond), .Rd(Rd), .Rn(Rn), .Rm(Rm),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .done(done), .err(err)
    );

    instr_encoder #(.BASE_ADDR(8'hFE)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .opCode(opCode), .op(op), .cond(cond), .Rd(Rd), .Rn(Rn), .Rm(Rm),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
        .mem_write(mem_write_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic [2:0]  opc;
        logic [1:0]  op;
        logic [2:0]  cond;
        logic [2:0]  rd;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        logic [15:0] s5;
        logic [15:0] s8;
        logic [15:0] exp;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t v);
        opCode = v.opc; op = v.op; cond = v.cond;
        Rd = v.rd; Rn = v.rn; Rm = v.rm; shift = v.sh;
        sximm5 = v.s5; sximm8 = v.s8;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        tv[0] = '{3'b110, 2'b10, 3'd7, 3'd3, 3'd7, 3'd7, 2'd3, 16'hFFFF, 16'hFFFB, 16'hD3FB};
        tv[1] = '{3'b101, 2'b00, 3'd5, 3'd2, 3'd1, 3'd0, 2'd1, 16'h001F, 16'h00AA, 16'hA148};
        tv[2] = '{3'b011, 2'b00, 3'd7, 3'd4, 3'd2, 3'd5, 2'd2, 16'h0003, 16'h0055, 16'h6283};
        tv[3] = '{3'b110, 2'b00, 3'd6, 3'd5, 3'd3, 3'd7, 2'd2, 16'h000F, 16'h0077, 16'hC0B7};
        tv[4] = '{3'b100, 2'b00, 3'd1, 3'd1, 3'd7, 3'd6, 2'd3, 16'hFFF0, 16'h0011, 16'h8730};
        tv[5] = '{3'b011, 2'b11, 3'd2, 3'd6, 3'd5, 3'd3, 2'd1, 16'h0001, 16'h007F, 16'h7E7F};
        tv[6] = '{3'b101, 2'b11, 3'd0, 3'd3, 3'd4, 3'd2, 2'd3, 16'h0000, 16'h0000, 16'hBC7A};
        tv[7] = '{3'b000, 2'b01, 3'd7, 3'd5, 3'd2, 3'd1, 2'd0, 16'h0000, 16'h0000, 16'h0AA1};
        tv[8] = '{3'b001, 2'b00, 3'd3, 3'd7, 3'd6, 3'd5, 2'd3, 16'hFFFF, 16'hFF80, 16'h2380};

        reset = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
        drive(tv[0]);
        #12;
        chk("rst_in_ready", 0, in_ready, 1'b0);
        chk("rst_in_ready_b", 0, in_ready_b, 1'b0);
        chk("rst_mem_write", 0, mem_write, 1'b0);
        chk("rst_mem_write_b", 0, mem_write_b, 1'b0);
        chk("rst_addr", 0, mem_addr, 8'h00);
        chk("rst_addr_b", 0, mem_addr_b, 8'hFE);
        chk("rst_wdata", 0, mem_wdata, 16'h0000);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_err", 0, err, 1'b0);
        chk("rst_err_b", 0, err_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", 0, in_ready, 1'b1);
        chk("post_rst_mem_write", 0, mem_write, 1'b0);

        // Back-to-back table: one word per cycle, each one cycle after accept.
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(tv[i]);
            in_valid = 1'b1;
            chk("tbl_in_ready", i, in_ready, 1'b1);
            step();
            chk("tbl_mem_write", i, mem_write, 1'b1);
            chk("tbl_wdata", i, mem_wdata, tv[i].exp);
            chk("tbl_wdata_b", i, mem_wdata_b, tv[i].exp);
            chk("tbl_addr", i, mem_addr, 8'(nw));
            chk("tbl_addr_b", i, mem_addr_b, 8'(8'hFE + 8'(nw)));
            nw++;
        end
        in_valid = 1'b0;
        step();
        chk("tbl_idle", 0, mem_write, 1'b0);

        // Backpressure: fill FIFO with mem_ready low.
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(tv[k]);
            in_valid = 1'b1;
            chk("bp_in_ready", k, in_ready, 1'b1);
            step();
            chk("bp_mem_write", k, mem_write, 1'b1);
            chk("bp_hold_data", k, mem_wdata, tv[0].exp);
            chk("bp_hold_addr", k, mem_addr, 8'(nw));
        end
        drive(tv[4]);
        chk("bp_full_ready", 0, in_ready, 1'b0);
        step();
        chk("bp_full_ready", 1, in_ready, 1'b0);
        chk("bp_hold_data", 4, mem_wdata, tv[0].exp);
        chk("bp_hold_addr", 4, mem_addr, 8'(nw));
        in_valid = 1'b0;
        mem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_write", j, mem_write, 1'b1);
            chk("bp_drain_data", j, mem_wdata, tv[j].exp);
            chk("bp_drain_addr", j, mem_addr, 8'(nw));
            step();
            nw++;
            if (j == 0)
                chk("bp_ready_back", 0, in_ready, 1'b1);
        end
        chk("bp_empty", 0, mem_write, 1'b0);
        drive(tv[4]);
        in_valid = 1'b1;
        chk("bp_fifth_ready", 0, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_fifth_data", 0, mem_wdata, tv[4].exp);
        chk("bp_fifth_addr", 0, mem_addr, 8'(nw));
        step();
        nw++;

        // LDR with sximm5 = 20: out of range.
        v = '{3'b011, 2'b00, 3'd0, 3'd4, 3'd2, 3'd1, 2'd0, 16'h0014, 16'h0000, 16'h6294};
        drive(v);
        in_valid = 1'b1;
        chk("imm_in_ready", 0, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
        chk("imm_err", 0, err, 1'b1);
        chk("imm_no_write", 0, mem_write, 1'b0);
        step();
        chk("imm_err_pulse", 0, err, 1'b0);
        chk("imm_no_write", 1, mem_write, 1'b0);
`else
        chk("imm_err", 0, err, 1'b0);
        chk("imm_write", 0, mem_write, 1'b1);
        chk("imm_trunc", 0, mem_wdata, 16'h6294);
        chk("imm_addr", 0, mem_addr, 8'(nw));
        step();
        nw++;
        chk("imm_idle", 0, mem_write, 1'b0);
`endif

        // Reset with words pending.
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(tv[k]);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("mid_pending", 0, mem_write, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_write", 0, mem_write, 1'b0);
        chk("mid_rst_addr", 0, mem_addr, 8'h00);
        chk("mid_rst_addr_b", 0, mem_addr_b, 8'hFE);
        chk("mid_rst_ready", 0, in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("mid_after_write", 0, mem_write, 1'b0);
        chk("mid_after_ready", 0, in_ready, 1'b1);
        nw = 0;
        mem_ready = 1'b1;

        // Branch then HALT; addresses FE, FF, 00 on the second instance.
        v = '{3'b001, 2'b00, 3'd0, 3'd5, 3'd5, 3'd5, 2'd2, 16'h0000, 16'hFFFE, 16'h20FE};
        drive(v);
        in_valid = 1'b1;
        step();
        chk("br_data", 0, mem_wdata, 16'h20FE);
        chk("br_addr", 0, mem_addr, 8'h00);
        chk("br_addr_b", 0, mem_addr_b, 8'hFE);
        v = '{3'b111, 2'b00, 3'd7, 3'd7, 3'd7, 3'd7, 2'd3, 16'hFFFF, 16'hFFFF, 16'hE000};
        drive(v);
        chk("halt_in_ready", 0, in_ready, 1'b1);
        step();
        drive(tv[0]);
        chk("halt_ready_low", 0, in_ready, 1'b0);
        chk("halt_write", 0, mem_write, 1'b1);
        chk("halt_data", 0, mem_wdata, 16'hE000);
        chk("halt_addr", 0, mem_addr, 8'h01);
        chk("halt_addr_b", 0, mem_addr_b, 8'hFF);
        chk("halt_done_early", 0, done, 1'b0);
        step();
        chk("done_set", 0, done, 1'b1);
        chk("done_idle", 0, mem_write, 1'b0);
        chk("done_ready", 0, in_ready, 1'b0);
        for (int k = 0; k < 3; k++)
            step();
        chk("done_sticky", 0, done, 1'b1);
        chk("done_sticky_b", 0, done_b, 1'b1);
        chk("done_no_accept", 0, mem_write, 1'b0);
        chk("final_addr", 0, mem_addr, 8'h02);
        chk("final_addr_b", 0, mem_addr_b, 8'h00);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder: the write-side counterpart of the instruction decoder. Accepts decoded instruction fields over a valid/ready handshake, packs them into 16-bit instruction words with the same field layout the decoder unpacks, buffers them in a small FIFO, and streams them into instruction memory through a held-request write port with an auto-incrementing address. Sits between the test/boot program loader and instruction RAM; a HALT word ends the load.

## Interface
- N_INSTR, 16, instruction word width
- N_REGISTER, 8, register count; N_NUMBERS = $clog2(N_REGISTER) = 3 index bits
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)
- ADDR_W, 8, memory address width
- BASE_ADDR, 0, first write address

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- opCode  in  3  bits [15:13]
- op  in  2  bits [12:11] (ALU_op for opcode 101)
- cond  in  3  branch condition
- Rd, Rn, Rm  in  N_NUMBERS each  register indices
- shift  in  2  shift code
- sximm5  in  16  sign-extended 5-bit immediate
- sximm8  in  16  sign-extended 8-bit immediate
- mem_write  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  N_INSTR  encoded word
- mem_ready  in  1  write accepted this cycle
- done  out  1  HALT word written
- err  out  1  one-cycle pulse, rejected bundle (only with INSTR_ENC_CHECK_EN)

## Operation
- Bits [15:13]=opCode, [12:11]=op always. Lower 11 bits by {opCode,op}:
  - 110_10 MOV imm: [10:8]=Rd, [7:0]=sximm8[7:0]
  - 011_11 load-imm: [10:8]=Rd, [7:0]=sximm8[7:0]
  - 110_00 MOV reg: [10:8]=000, [7:5]=Rd, [4:3]=shift, [2:0]=Rm
  - 101_xx ALU: [10:8]=Rn, [7:5]=Rd, [4:3]=shift, [2:0]=Rm
  - 011_00 LDR, 100_00 STR: [10:8]=Rn, [7:5]=Rd, [4:0]=sximm5[4:0]
  - 001_xx branch: [10:8]=cond, [7:0]=sximm8[7:0]
  - 111_xx HALT: [10:0]=0
  - any other: ALU layout
- States: LOAD (accepting), DRAIN (HALT accepted, FIFO non-empty), DONE.
- in_ready = (state==LOAD) && !fifo_full. No push/pop bypass when full.
- Accepted HALT: pushed, state→DRAIN; in_ready low from next cycle.
- FIFO head drives mem_wdata; mem_write = !fifo_empty. Pop and mem_addr+1 on mem_write && mem_ready. Address wraps 2^ADDR_W−1 → 0.
- DRAIN→DONE on pop of the HALT word; done high from then, sticky until reset.
- Simultaneous push and pop: count unchanged, both take effect.

## Timing
- Reset (async): in_ready=0 while asserted, 1 the first cycle after release; mem_write=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, FIFO empty, state LOAD.
- Latency: bundle accepted at edge N → mem_write high with its word in the cycle after N.
- mem_addr/mem_wdata stable while mem_write && !mem_ready.
- Throughput: one word per cycle with mem_ready held high.
- Reset mid-transfer: FIFO contents discarded, address restarts at BASE_ADDR.

## Configuration
- INSTR_ENC_CHECK_EN defined: bundle rejected (not pushed, err pulses the cycle after acceptance) if a used immediate falls outside its signed range (sximm5 ∉ [−16,15] for LDR/STR; sximm8 ∉ [−128,127] for imm8 formats). in_ready unaffected.
- Undefined: immediates silently truncated; err tied 0.

## Structure
- Package instr_pkg: opcode/op localparams (OP_MOV, OP_ALU, OP_LDR, OP_STR, OP_B, OP_HALT), format enum, encoder state enum, N_INSTR.
- Sub-module instr_fifo: synchronous FIFO, parameterised width/depth, full/empty/count.

## Test plan
- MOV R3,#−5 (110_10, sximm8=16'hFFFB), mem_ready=1 → write 16'hD3FB at addr 0 one cycle after accept.
- ADD R2,R1,R0 LSL (101_00, Rn=1, Rd=2, shift=01, Rm=0) then LDR R4,[R2,#3] → 16'hA148 @0, 16'h6283 @1.
- mem_ready=0, push 5 bundles → in_ready low after 4th accept; addr/data held; release → 4 writes in order, in_ready returns.
- B cond=000 imm −2 then HALT → 16'h20FE, 16'hE000; in_ready low after HALT; done high after HALT write.
- BASE_ADDR=8'hFE, three writes → addrs FE, FF, 00.
- With INSTR_ENC_CHECK_EN: LDR sximm5=16'd20 → err pulse, no write; without: word 16'h6294-style truncated write (imm field 10100).
